// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, sync, active video and line/frame strobes.
// Optional macro VGA_SYNC_PIPE_DELAY_EN delays hsync/vsync/active by PIPE_DELAY clk cycles.
module vga_timing_gen #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      pix_en,
  output logic [$clog2(WIDTH)-1:0]  pxl_x,
  output logic [$clog2(HEIGHT)-1:0] pxl_y,
  output logic                      active,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      line_start,
  output logic                      frame_start
);

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(WIDTH);
  localparam logic [HW-1:0] HS_BEG = HW'(WIDTH + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(WIDTH + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(HEIGHT);
  localparam logic [VW-1:0] VS_BEG = VW'(HEIGHT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(HEIGHT + V_FP + V_SYNC - 1);
  localparam logic [XW-1:0] X_HOLD = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_HOLD = YW'(HEIGHT - 1);

  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
  end

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          act_nxt, hs_nxt, vs_nxt;
  logic          act_r, hs_r, vs_r;

  // pix_en is a plain per-edge qualifier (no handshake): an edge with pix_en=1
  // advances the raster by one pixel, an edge with pix_en=0 holds everything.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_nxt = h_cnt + HW'(1);
      end
    end
  end

  // Decode from the next counter values so outputs move on the same edge as the counters.
  always_comb begin
    act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    x_nxt   = (h_nxt < H_VIS) ? h_nxt[XW-1:0] : X_HOLD;
    y_nxt   = (v_nxt < V_VIS) ? v_nxt[YW-1:0] : Y_HOLD;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      pxl_x       <= X_HOLD;
      pxl_y       <= Y_HOLD;
      act_r       <= 1'b0;
      hs_r        <= ~SYNC_POL;
      vs_r        <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pxl_x       <= x_nxt;
      pxl_y       <= y_nxt;
      act_r       <= act_nxt;
      hs_r        <= hs_nxt;
      vs_r        <= vs_nxt;
      line_start  <= pix_en && (h_nxt == '0);
      frame_start <= pix_en && (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_SYNC_PIPE_DELAY_EN
  // Each stage holds {active, hsync, vsync}; delay counts clk cycles, not pixels.
  logic [2:0] dly_q [PIPE_DELAY];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= {1'b0, ~SYNC_POL, ~SYNC_POL};
    end else begin
      dly_q[0] <= {act_r, hs_r, vs_r};
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign {active, hsync, vsync} = dly_q[PIPE_DELAY-1];
`else
  assign active = act_r;
  assign hsync  = hs_r;
  assign vsync  = vs_r;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the arcade template; sits directly upstream of every per-pixel drawer (star field, sprites, text) and the VGA output stage.
- Produces the pixel coordinates pxl_x/pxl_y that drawers consume, plus hsync, vsync, active-video and frame/line strobes.
- Default timing is 640x480@60 (800x525 total); a pixel clock-enable allows running from the 50 MHz board clock.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 1, sync/active delay in clk cycles; used only with the optional feature; legal range 1..4

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel advance enable; tie to 1 for one pixel per clk
- pxl_x  out  $clog2(WIDTH)  visible column
- pxl_y  out  $clog2(HEIGHT)  visible row
- active  out  1  high while pixel is in the visible area
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- line_start  out  1  one-clk pulse when h counter enters 0, every line
- frame_start  out  1  one-clk pulse when counters enter (0,0)

Behaviour:
- Derived totals: H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP; V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP.
- Internal counters h_cnt and v_cnt are sized $clog2(H_TOTAL) and $clog2(V_TOTAL).
- Counters advance only on a clk edge with pix_en=1:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on that h wrap, and wraps V_TOTAL-1 -> 0.
- All outputs are registered and decoded from the next counter values, so they change on the same edge as the counters. No extra latency.
- active = (h<WIDTH) && (v<HEIGHT).
- hsync asserted for h in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC-1].
- vsync asserted for v in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC-1]; it therefore changes only on edges where h enters 0.
- pxl_x = h_cnt while h<WIDTH, else held at WIDTH-1.
- pxl_y = v_cnt while v<HEIGHT, else held at HEIGHT-1.
- Consequence: (pxl_x,pxl_y)=(0,0) occurs exactly once per frame, lasting one pix_en period. Downstream drawers rely on this to reseed.
- line_start and frame_start are exactly one clk wide regardless of pix_en rate, and are 0 on edges with pix_en=0.
- Reset (asynchronous, any time, including mid-frame):
  - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - pxl_x=WIDTH-1, pxl_y=HEIGHT-1.
  - active=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0.
  - The first pix_en edge after release yields (0,0), active=1, line_start=1, frame_start=1.
- pix_en held 0: all outputs hold and strobes stay 0. There is no timeout.

Optional Feature:
- Macro VGA_SYNC_PIPE_DELAY_EN.
- Defined: hsync, vsync and active are additionally delayed by PIPE_DELAY clk cycles (not pix_en periods) through shift registers. This aligns them with registered drawer outputs.
  - The delay stages reset to active=0 and sync deasserted.
  - pxl_x, pxl_y, line_start and frame_start remain undelayed.
- Undefined: no delay stages; all outputs are aligned as described in Behaviour. PIPE_DELAY is ignored.

Test Plan:
- Reset release, pix_en=1, defaults -> first edge gives pxl=(0,0), active=1, frame_start=1 for one clk; next frame_start exactly 420000 clks later.
- Line scan, defaults -> active falls when h=640; pxl_x holds 639 for h=640..799; hsync low for h=656..751 (96 clks); line_start every 800 clks.
- Frame scan, defaults -> pxl_y holds 479 for v=480..524; vsync low for v=490..491 (1600 clks), both edges coincident with line_start.
- pix_en alternating 1/0 -> counters advance every 2 clks; (0,0) held 2 clks; frame_start still one clk wide; frame period 840000 clks.
- resetN pulsed low at h=300, v=200 -> outputs take reset values immediately, without waiting for clk; after release, first pix_en edge gives (0,0) with frame_start=1.
- VGA_SYNC_PIPE_DELAY_EN, PIPE_DELAY=2, pix_en=1 -> hsync falls 2 clks after h reaches 656; active falls 2 clks after pxl_x first holds 639 past h=639; pxl_x timing unchanged from the non-macro build.
